// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave bridging to a 1-cycle-latency synchronous single-port SRAM.
// Ports: AHB-Lite slave side (HSEL..HRESP), SRAM side (sram_en..sram_rdata).
module ahbl_sram_slave #(
  parameter int AW = 10
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDW,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [3:0]    lanes_q;

  logic          accept;
  logic          illegal;
  logic          open_q;
  logic          rd_now;
  logic [3:0]    lanes;
  logic [AW-1:0] haddr_w;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};
  assign haddr_w = HADDR[AW+1:2];

  // Gated by HRESETn so nothing reaches the SRAM while reset is held.
  assign accept = HRESETn & HSEL & HREADY & HTRANS[1];

  // States in which an address phase may legitimately be taken.
  assign open_q = (state_q == S_IDLE) | (state_q == S_WR) |
                  (state_q == S_RD) | (state_q == S_ERR2);

  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      HSIZE == 3'd0: illegal = 1'b0;
      HSIZE == 3'd1: illegal = HADDR[0];
      HSIZE == 3'd2: illegal = |HADDR[1:0];
      default:       illegal = 1'b1;
    endcase
  end

  always_comb begin
    lanes = 4'b0000;
    unique case (1'b1)
      HSIZE == 3'd0: lanes = 4'b0001 << HADDR[1:0];
      HSIZE == 3'd1: lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default:       lanes = 4'b1111;
    endcase
  end

  // A read can go straight to the SRAM unless a write owns the port.
  assign rd_now = accept & open_q & ~illegal & ~HWRITE &
                  (state_q != S_WR);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      lanes_q <= '0;
    end else if (accept && open_q && !illegal) begin
      addr_q  <= haddr_w;
      lanes_q <= lanes;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RDW:   state_d = S_RD;
      S_ERR1:  state_d = S_ERR2;
      default: begin
        if (!accept)              state_d = S_IDLE;
        else if (illegal)         state_d = S_ERR1;
        else if (HWRITE)          state_d = S_WR;
        else if (state_q == S_WR) state_d = S_RDW;
        else                      state_d = S_RD;
      end
    endcase
  end

  always_comb begin
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = 32'h0;
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = haddr_w;
    sram_wdata = 32'h0;
    case (state_q)
      S_WR: begin
        sram_en    = 1'b1;
        sram_we    = lanes_q;
        sram_addr  = addr_q;
        sram_wdata = HWDATA;
      end
      S_RDW: begin
        HREADYOUT = 1'b0;
        sram_en   = 1'b1;
        sram_addr = addr_q;
      end
      S_RD: begin
        HRDATA = sram_rdata;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase
    if (rd_now) begin
      sram_en   = 1'b1;
      sram_addr = haddr_w;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave with a behavioural SRAM.
// Single slave on the bus: HREADY is looped back from HREADYOUT.
module tb_ahbl_sram_slave;

  localparam int AW = 10;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = 32'h0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd0;
  logic          HWRITE = 1'b0;
  logic [31:0]   HWDATA = 32'h0;
  logic          HREADY;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = 32'h0;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          fill = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahbl_sram_slave #(.AW(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  always @(posedge HCLK) begin
    if (fill) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b])
          mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [2:0] sz,
                      input logic [31:0] a);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE = sz;
    HADDR = a;
    #1;
  endtask

  task automatic idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE = 3'd0;
    HADDR = 32'h0;
    #1;
  endtask

  logic [2:0]  esz [3];
  logic [31:0] ead [3];

  initial begin
    esz[0] = 3'd2; ead[0] = 32'h2;
    esz[1] = 3'd3; ead[1] = 32'h0;
    esz[2] = 3'd1; ead[2] = 32'h1;

    idle();
    repeat (2) @(posedge HCLK);
    #1;
    fill = 1'b0;

    // reset state, with a read presented during reset
    xfer(1'b0, 3'd2, 32'h0);
    check("rst_rdy", 32'(HREADYOUT), 32'd1);
    check("rst_resp", 32'(HRESP), 32'd0);
    check("rst_en", 32'(sram_en), 32'd0);
    check("rst_we", 32'(sram_we), 32'd0);
    check("rst_rdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    #1;
    check("first_en", 32'(sram_en), 32'd1);
    step();
    idle();
    check("first_rd", HRDATA, pat(0));
    step();

    // word write then read: one wait state
    HWDATA = 32'h0;
    xfer(1'b1, 3'd2, 32'h10);
    check("wr_aph_en", 32'(sram_en), 32'd0);
    step();
    HWDATA = 32'hDEADBEEF;
    xfer(1'b0, 3'd2, 32'h10);
    check("wr_en", 32'(sram_en), 32'd1);
    check("wr_we", 32'(sram_we), 32'hF);
    check("wr_addr", 32'(sram_addr), 32'd4);
    check("wr_wdata", sram_wdata, 32'hDEADBEEF);
    check("wr_rdy", 32'(HREADYOUT), 32'd1);
    step();
    idle();
    check("rdw_rdy", 32'(HREADYOUT), 32'd0);
    check("rdw_en", 32'(sram_en), 32'd1);
    check("rdw_we", 32'(sram_we), 32'd0);
    check("rdw_rdata", HRDATA, 32'h0);
    step();
    check("rd_rdy", 32'(HREADYOUT), 32'd1);
    check("rd_data", HRDATA, 32'hDEADBEEF);
    check("rd_resp", 32'(HRESP), 32'd0);
    step();

    // byte write into upper lane
    xfer(1'b1, 3'd2, 32'h10);
    step();
    HWDATA = 32'h0;
    xfer(1'b1, 3'd0, 32'h13);
    check("b0_we", 32'(sram_we), 32'hF);
    step();
    HWDATA = 32'hAA000000;
    xfer(1'b0, 3'd2, 32'h10);
    check("byte_we", 32'(sram_we), 32'h8);
    check("byte_addr", 32'(sram_addr), 32'd4);
    step();
    idle();
    check("byte_rdw", 32'(HREADYOUT), 32'd0);
    step();
    check("byte_rd", HRDATA, 32'hAA000000);
    step();

    // back-to-back reads
    xfer(1'b0, 3'd2, 32'h0);
    step();
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) xfer(1'b0, 3'd2, 32'(4 * k));
      else idle();
      check("b2b_rdy", 32'(HREADYOUT), 32'd1);
      check("b2b_data", HRDATA, pat(k - 1));
      step();
    end

    // illegal transfers: two-cycle ERROR
    for (int v = 0; v < 3; v++) begin
      xfer(1'b0, esz[v], ead[v]);
      check("err_aph_en", 32'(sram_en), 32'd0);
      step();
      idle();
      check("err1_rdy", 32'(HREADYOUT), 32'd0);
      check("err1_resp", 32'(HRESP), 32'd1);
      check("err1_en", 32'(sram_en), 32'd0);
      step();
      if (v == 2) xfer(1'b0, 3'd2, 32'h8);
      else idle();
      check("err2_rdy", 32'(HREADYOUT), 32'd1);
      check("err2_resp", 32'(HRESP), 32'd1);
      check("err2_en", 32'(sram_en), (v == 2) ? 32'd1 : 32'd0);
      step();
      idle();
      check("post_err_resp", 32'(HRESP), 32'd0);
      if (v == 2) check("post_err_rd", HRDATA, pat(2));
      step();
    end

    // address aliasing above the SRAM size
    xfer(1'b1, 3'd2, (32'd4 << AW) + 32'h4);
    step();
    HWDATA = 32'h12345678;
    idle();
    check("alias_addr", 32'(sram_addr), 32'd1);
    check("alias_we", 32'(sram_we), 32'hF);
    step();
    xfer(1'b0, 3'd2, 32'h4);
    check("alias_rd_addr", 32'(sram_addr), 32'd1);
    step();
    idle();
    check("alias_rd", HRDATA, 32'h12345678);
    step();

    // upper half-word lanes
    xfer(1'b1, 3'd1, 32'h16);
    step();
    HWDATA = 32'hBEEF0000;
    idle();
    check("half_we", 32'(sram_we), 32'hC);
    check("half_addr", 32'(sram_addr), 32'd5);
    step();

    // reset asserted during the read wait state
    xfer(1'b1, 3'd2, 32'h20);
    step();
    HWDATA = 32'h0BADF00D;
    xfer(1'b0, 3'd2, 32'h20);
    step();
    idle();
    check("pre_rst_rdw", 32'(HREADYOUT), 32'd0);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(HREADYOUT), 32'd1);
    check("mid_rst_resp", 32'(HRESP), 32'd0);
    check("mid_rst_en", 32'(sram_en), 32'd0);
    HRESETn = 1'b1;
    xfer(1'b0, 3'd2, 32'h20);
    step();
    idle();
    check("post_rst_rdy", 32'(HREADYOUT), 32'd1);
    check("post_rst_rd", HRDATA, 32'h0BADF00D);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 SHALL have parameter AW, default 10, meaning SRAM word-address width (4 KB at default).
REQ-002 SHALL have port HCLK, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port HRESETn, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port HSEL, input, 1, slave select from the AHB-Lite decoder.
REQ-005 SHALL have port HADDR, input, 32, transfer address (address phase).
REQ-006 SHALL have port HTRANS, input, 2, transfer type; bit 1 set means NONSEQ/SEQ.
REQ-007 SHALL have port HSIZE, input, 3, transfer size: 0 byte, 1 half-word, 2 word.
REQ-008 SHALL have port HWRITE, input, 1, write control (address phase).
REQ-009 SHALL have port HWDATA, input, 32, write data (data phase).
REQ-010 SHALL have port HREADY, input, 1, bus ready; address phase is sampled only when 1.
REQ-011 SHALL have port HRDATA, output, 32, read data.
REQ-012 SHALL have port HREADYOUT, output, 1, slave ready; 0 inserts a wait state.
REQ-013 SHALL have port HRESP, output, 1, 0 = OKAY, 1 = ERROR.
REQ-014 SHALL have ports sram_en (output, 1), sram_we (output, 4), sram_addr (output, AW), sram_wdata (output, 32) and sram_rdata (input, 32), for a synchronous single-port SRAM with 1-cycle read latency.

Function
REQ-015 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] are all 1 on a rising edge; IDLE/BUSY or unselected cycles SHALL get a zero-wait OKAY with no SRAM access.
REQ-016 SHALL derive byte lanes:
- HSIZE 0: one-hot lane at HADDR[1:0].
- HSIZE 1: 4'b0011 when HADDR[1]=0, 4'b1100 when HADDR[1]=1.
- HSIZE 2: 4'b1111.
REQ-017 SHALL address SRAM with HADDR[AW+1:2] only; higher address bits are ignored (aliasing wrap).
REQ-018 SHALL treat the following as illegal: HSIZE>2, half-word with HADDR[0]=1, word with HADDR[1:0]!=0.
REQ-019 SHALL implement FSM states IDLE, WR, RD, RDW, ERR1 and ERR2, with state = data phase of the last accepted transfer.
REQ-020 SHALL handle an accepted legal read in a non-WR state as follows:
- Address phase: sram_en=1, sram_we=0, sram_addr from HADDR.
- Next state RD: HREADYOUT=1, HRDATA=sram_rdata (zero wait).
REQ-021 SHALL handle an accepted legal write by latching address and lanes and entering WR, where it drives sram_en=1, sram_we=lanes, sram_wdata=HWDATA, HREADYOUT=1.
REQ-022 SHALL handle a read accepted while in WR (SRAM port busy) as follows:
- Latch the read address and enter RDW.
- RDW: issue the SRAM read with HREADYOUT=0.
- Then enter RD with HREADYOUT=1 and the data.
- Exactly one wait state.
REQ-023 SHALL return data in a read following a write to the same word that reflects the write.
REQ-024 SHALL handle an illegal accepted transfer as follows:
- No SRAM access.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- A transfer presented during ERR2 is accepted normally.
REQ-025 SHALL drive HRESP=0 in all other states and HRDATA=32'h0 outside RD.
REQ-026 SHALL drive sram_en=0 and sram_we=0 in all cycles not covered by REQ-020/021/022.
REQ-027 SHALL NOT accept a new address phase while HREADYOUT=0 (RDW, ERR1), because HREADY is then 0.
REQ-028 SHALL support back-to-back write->write and read->read at full rate with no wait states.

Reset
REQ-029 SHALL, while HRESETn=0, force state IDLE, HREADYOUT=1, HRESP=0, sram_en=0, sram_we=0 and clear latched address/lanes; a transfer in flight is abandoned.
REQ-030 SHALL accept a transfer on the first rising edge after HRESETn deasserts.

Verification
REQ-031 SHALL be verified with: word write 0xDEADBEEF @0x10, then word read @0x10 -> exactly one wait state (HREADYOUT low one cycle), HRDATA=0xDEADBEEF, HRESP=0.
REQ-032 SHALL be verified with: byte write 0xAA @0x13 after word 0x00000000 @0x10, then word read @0x10 -> sram_we=4'b1000 on the write, read returns 0xAA000000.
REQ-033 SHALL be verified with: four back-to-back word reads @0x0,0x4,0x8,0xC -> HREADYOUT constantly 1, data returned in consecutive cycles.
REQ-034 SHALL be verified with: word read @0x2 (misaligned) or HSIZE=3 -> HRESP=1 for two cycles, HREADYOUT 0 then 1, sram_en stays 0.
REQ-035 SHALL be verified with: word write @(4<<AW)+0x4 with AW=10 -> sram_addr=1 (alias of 0x4).
REQ-036 SHALL be verified with: HRESETn pulsed low during RDW -> HREADYOUT=1, HRESP=0, sram_en=0 immediately; next read completes normally.
